// File: rtl/peripheral_event_packer.sv
// Keyboard/mouse event assembler with per-channel FIFOs and a
// round-robin serialiser onto the shared payload-paced tx port.
module peripheral_event_packer #(
  parameter int MOUSE_BYTES   = 4,
  parameter int KBD_DEPTH     = 4,
  parameter int MOUSE_DEPTH   = 2,
  parameter int MOUSE_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       online,
  input  logic       busy,
  input  logic       payload,
  input  logic       keyboard_valid,
  input  logic       keyboard_error,
  input  logic [7:0] keyboard_data,
  input  logic       mouse_valid,
  input  logic       mouse_error,
  input  logic [7:0] mouse_data,
  output logic       tx_action,
  output logic       tx_channel,
  output logic [2:0] tx_length,
  output logic [7:0] tx_data,
  output logic [7:0] kbd_drop_count,
  output logic [7:0] mouse_drop_count
);

  localparam int MW  = MOUSE_BYTES * 8;
  localparam int KAW = $clog2(KBD_DEPTH);
  localparam int MAW = $clog2(MOUSE_DEPTH);
  localparam int TW  = $clog2(MOUSE_TIMEOUT + 1);
  localparam logic [KAW:0]   K_FULL = (KAW+1)'(KBD_DEPTH);
  localparam logic [MAW:0]   M_FULL = (MAW+1)'(MOUSE_DEPTH);
  localparam logic [TW-1:0]  T_LAST = TW'(MOUSE_TIMEOUT - 1);
  localparam logic [1:0]     M_LAST = 2'(MOUSE_BYTES - 1);
  localparam logic [2:0]     M_LEN  = 3'(MOUSE_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_n;

  logic          ext, brk;
  logic [1:0]    m_idx;
  logic [MW-9:0] m_shift;
  logic [TW-1:0] m_timer;

  logic [9:0]    k_mem [KBD_DEPTH];
  logic [MW-1:0] m_mem [MOUSE_DEPTH];
  logic [KAW-1:0] k_wp, k_rp;
  logic [MAW-1:0] m_wp, m_rp;
  logic [KAW:0]  k_cnt;
  logic [MAW:0]  m_cnt;

  logic          last_kbd;
  logic [31:0]   ev_buf;
  logic [1:0]    tx_idx;

  logic k_code, k_push, k_acc, k_drop;
  logic m_push, m_acc, m_abort, m_drop;
  logic grant_m, start, pop_k, pop_m, last_byte;
  logic [31:0] k_bytes, m_bytes;

  assign k_code  = keyboard_data != 8'hE0 && keyboard_data != 8'hF0;
  assign k_push  = online && keyboard_valid && !keyboard_error && k_code;
  assign k_acc   = k_push && (k_cnt != K_FULL || pop_k);
  assign k_drop  = (online && keyboard_error) || (k_push && !k_acc);

  assign m_push  = online && mouse_valid && !mouse_error && m_idx == M_LAST;
  assign m_abort = online && (mouse_error ||
                   (!mouse_valid && m_idx != 2'd0 && m_timer == T_LAST));
  assign m_acc   = m_push && (m_cnt != M_FULL || pop_m);
  assign m_drop  = m_abort || (m_push && !m_acc);

  assign grant_m = m_cnt != '0 && (k_cnt == '0 || last_kbd);
  assign start   = state == IDLE && online && !busy &&
                   (k_cnt != '0 || m_cnt != '0);
  assign pop_k   = start && !grant_m;
  assign pop_m   = start && grant_m;

  assign k_bytes = {k_mem[k_rp][9] ? 8'hE0 : 8'h00,
                    k_mem[k_rp][8] ? 8'hF0 : 8'h00,
                    k_mem[k_rp][7:0], 8'h00};
  assign m_bytes = 32'(m_mem[m_rp]) << (32 - MW);
  assign last_byte = 3'(tx_idx) + 3'd1 == tx_length;

  always_ff @(posedge clk) begin
    if (!reset || !online || keyboard_error) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (keyboard_valid) begin
      unique case (1'b1)
        keyboard_data == 8'hE0: ext <= 1'b1;
        keyboard_data == 8'hF0: brk <= 1'b1;
        default: begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !online) begin
      m_idx   <= '0;
      m_timer <= '0;
      m_shift <= '0;
    end else if (mouse_error) begin
      m_idx   <= '0;
      m_timer <= '0;
    end else if (mouse_valid) begin
      m_timer <= '0;
      m_shift <= {m_shift[MW-17:0], mouse_data};
      m_idx   <= (m_idx == M_LAST) ? 2'd0 : m_idx + 2'd1;
    end else if (m_idx != 2'd0) begin
      if (m_timer == T_LAST) begin
        m_idx   <= '0;
        m_timer <= '0;
      end else begin
        m_timer <= m_timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      kbd_drop_count   <= '0;
      mouse_drop_count <= '0;
    end else begin
      if (k_drop && kbd_drop_count != 8'hFF)
        kbd_drop_count <= kbd_drop_count + 8'd1;
      if (m_drop && mouse_drop_count != 8'hFF)
        mouse_drop_count <= mouse_drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (k_acc) k_mem[k_wp] <= {ext, brk, keyboard_data};
    if (m_acc) m_mem[m_wp] <= {m_shift, mouse_data};
  end

  always_ff @(posedge clk) begin
    if (!reset || !online) begin
      k_wp  <= '0;
      k_rp  <= '0;
      k_cnt <= '0;
      m_wp  <= '0;
      m_rp  <= '0;
      m_cnt <= '0;
    end else begin
      if (k_acc) k_wp <= k_wp + KAW'(1);
      if (pop_k) k_rp <= k_rp + KAW'(1);
      if (m_acc) m_wp <= m_wp + MAW'(1);
      if (pop_m) m_rp <= m_rp + MAW'(1);
      k_cnt <= k_cnt + (KAW+1)'(k_acc) - (KAW+1)'(pop_k);
      m_cnt <= m_cnt + (MAW+1)'(m_acc) - (MAW+1)'(pop_m);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = SEND;
      SEND: if (payload && last_byte) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!online) state_n = IDLE;
  end

  // Event bytes shift out MSB-first from a left-aligned buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_action  <= 1'b0;
      tx_channel <= 1'b0;
      tx_length  <= '0;
      tx_data    <= '0;
      ev_buf     <= '0;
      tx_idx     <= '0;
      last_kbd   <= 1'b0;
    end else if (!online) begin
      tx_action <= 1'b0;
      tx_data   <= '0;
      tx_idx    <= '0;
    end else begin
      tx_action <= start;
      if (state == IDLE) begin
        tx_data <= '0;
        if (start) begin
          ev_buf     <= grant_m ? m_bytes : k_bytes;
          tx_channel <= grant_m;
          tx_length  <= grant_m ? M_LEN : 3'd3;
          tx_idx     <= '0;
          last_kbd   <= !grant_m;
        end
      end else if (payload) begin
        tx_data <= ev_buf[31:24];
        ev_buf  <= {ev_buf[23:0], 8'h00};
        tx_idx  <= tx_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_event_packer.sv
// Directed and randomized bench for peripheral_event_packer with an
// event-level monitor and queue-based reference model.
module tb_peripheral_event_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, online, busy, payload;
  logic       keyboard_valid, keyboard_error;
  logic [7:0] keyboard_data;
  logic       mouse_valid, mouse_error;
  logic [7:0] mouse_data;
  logic       tx_action, tx_channel;
  logic [2:0] tx_length;
  logic [7:0] tx_data, kbd_drop_count, mouse_drop_count;

  peripheral_event_packer #(
    .MOUSE_BYTES(4), .KBD_DEPTH(4), .MOUSE_DEPTH(2), .MOUSE_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .online(online), .busy(busy),
    .payload(payload),
    .keyboard_valid(keyboard_valid), .keyboard_error(keyboard_error),
    .keyboard_data(keyboard_data),
    .mouse_valid(mouse_valid), .mouse_error(mouse_error),
    .mouse_data(mouse_data),
    .tx_action(tx_action), .tx_channel(tx_channel),
    .tx_length(tx_length), .tx_data(tx_data),
    .kbd_drop_count(kbd_drop_count),
    .mouse_drop_count(mouse_drop_count)
  );

  int checks = 0;
  int errors = 0;

  logic [35:0] got[$];
  logic [35:0] exp_q[$];
  logic [35:0] exp_k[$];
  logic [35:0] exp_m[$];
  logic [35:0] got_k[$];
  logic [35:0] got_m[$];

  int          n_act = 0;
  logic        mon_on = 1'b0;
  int          mon_n;
  logic [2:0]  mon_len;
  logic        mon_ch;
  logic [31:0] mon_acc;
  logic        p_act, p_pl, p_on;

  // Transaction monitor: one entry per fully transmitted event.
  always @(posedge clk) begin
    p_act = tx_action;
    p_pl  = payload;
    p_on  = online && reset;
    if (!p_on) begin
      mon_on = 1'b0;
    end else begin
      if (p_act) begin
        n_act++;
        mon_on  = 1'b1;
        mon_ch  = tx_channel;
        mon_len = tx_length;
        mon_n   = 0;
        mon_acc = '0;
      end
      if (mon_on && p_pl) begin
        #1;
        mon_acc = mon_acc | (32'(tx_data) << (24 - 8 * mon_n));
        mon_n++;
        if (mon_n == int'(mon_len)) begin
          got.push_back({mon_ch, mon_len, mon_acc});
          mon_on = 1'b0;
        end
      end
    end
  end

  function automatic logic [35:0] kev(input logic e, input logic b,
                                      input logic [7:0] c);
    return {1'b0, 3'd3, e ? 8'hE0 : 8'h00, b ? 8'hF0 : 8'h00, c, 8'h00};
  endfunction

  function automatic logic [35:0] mev(input logic [31:0] p);
    return {1'b1, 3'd4, p};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_k(input logic [7:0] b);
    keyboard_valid = 1'b1;
    keyboard_data  = b;
    tick();
    keyboard_valid = 1'b0;
  endtask

  task automatic send_m(input logic [7:0] b);
    mouse_valid = 1'b1;
    mouse_data  = b;
    tick();
    mouse_valid = 1'b0;
  endtask

  task automatic send_mp(input logic [31:0] p);
    for (int i = 3; i >= 0; i--) send_m(p[8*i +: 8]);
  endtask

  task automatic wait_action(input string tag);
    for (int k = 0; k < 50 && tx_action !== 1'b1; k++) tick();
    check(tag, tx_action, 1'b1);
  endtask

  task automatic cmp_got(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check(tag, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_action"}, tx_action, 1'b0);
    check({tag, "_channel"}, tx_channel, 1'b0);
    check({tag, "_length"}, tx_length, 3'd0);
    check({tag, "_data"}, tx_data, 8'h00);
    check({tag, "_kdrop"}, kbd_drop_count, 8'h00);
    check({tag, "_mdrop"}, mouse_drop_count, 8'h00);
  endtask

  logic        e_f, b_f;
  logic [7:0]  code;
  logic [31:0] pk;
  int          n0;

  initial begin
    reset = 1'b0; online = 1'b1; busy = 1'b0; payload = 1'b0;
    keyboard_valid = 1'b0; keyboard_error = 1'b0; keyboard_data = '0;
    mouse_valid = 1'b0; mouse_error = 1'b0; mouse_data = '0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b1;
    tick();

    // keyboard E0 F0 75, exact latency and byte pacing
    send_k(8'hE0);
    send_k(8'hF0);
    send_k(8'h75);
    check("t1_early", tx_action, 1'b0);
    tick();
    check("t1_action", tx_action, 1'b1);
    check("t1_channel", tx_channel, 1'b0);
    check("t1_length", tx_length, 3'd3);
    check("t1_idle_data", tx_data, 8'h00);
    payload = 1'b1;
    tick();
    check("t1_b0", tx_data, 8'hE0);
    check("t1_pulse", tx_action, 1'b0);
    payload = 1'b0;
    tick();
    check("t1_hold", tx_data, 8'hE0);
    payload = 1'b1;
    tick();
    check("t1_b1", tx_data, 8'hF0);
    tick();
    check("t1_b2", tx_data, 8'h75);
    payload = 1'b0;
    tick();
    check("t1_end", tx_data, 8'h00);
    got.delete();

    // mouse packet
    send_mp(32'h0801FF00);
    check("t2_early", tx_action, 1'b0);
    tick();
    check("t2_action", tx_action, 1'b1);
    check("t2_channel", tx_channel, 1'b1);
    check("t2_length", tx_length, 3'd4);
    payload = 1'b1;
    tick(); check("t2_b0", tx_data, 8'h08);
    tick(); check("t2_b1", tx_data, 8'h01);
    tick(); check("t2_b2", tx_data, 8'hFF);
    tick(); check("t2_b3", tx_data, 8'h00);
    payload = 1'b0;
    tick();
    check("t2_end", tx_data, 8'h00);
    got.delete();

    // round robin between both channels
    busy = 1'b1;
    send_k(8'h1C);
    send_mp(32'h11223344);
    send_k(8'h32);
    send_mp(32'h55667788);
    busy = 1'b0;
    payload = 1'b1;
    repeat (40) tick();
    payload = 1'b0;
    exp_q.push_back(kev(1'b0, 1'b0, 8'h1C));
    exp_q.push_back(mev(32'h11223344));
    exp_q.push_back(kev(1'b0, 1'b0, 8'h32));
    exp_q.push_back(mev(32'h55667788));
    cmp_got("t3_order");

    // keyboard overflow and saturation
    busy = 1'b1;
    for (int c = 8'h11; c <= 8'h15; c++) send_k(8'(c));
    check("t4_drop1", kbd_drop_count, 8'd1);
    busy = 1'b0;
    payload = 1'b1;
    repeat (40) tick();
    payload = 1'b0;
    for (int c = 8'h11; c <= 8'h14; c++)
      exp_q.push_back(kev(1'b0, 1'b0, 8'(c)));
    cmp_got("t4_fifo");
    keyboard_error = 1'b1;
    repeat (300) tick();
    keyboard_error = 1'b0;
    check("t4_sat", kbd_drop_count, 8'hFF);

    // mouse timeout, then clean packet
    send_m(8'hA0);
    send_m(8'hA1);
    repeat (14) tick();
    check("t5_no_timeout", mouse_drop_count, 8'd0);
    repeat (4) tick();
    check("t5_timeout", mouse_drop_count, 8'd1);
    send_mp(32'hB1B2B3B4);
    payload = 1'b1;
    repeat (20) tick();
    payload = 1'b0;
    exp_q.push_back(mev(32'hB1B2B3B4));
    cmp_got("t5_clean");
    check("t5_mdrop", mouse_drop_count, 8'd1);

    // keyboard error clears prefix
    send_k(8'hE0);
    keyboard_error = 1'b1;
    tick();
    keyboard_error = 1'b0;
    send_k(8'h1C);
    payload = 1'b1;
    repeat (20) tick();
    payload = 1'b0;
    exp_q.push_back(kev(1'b0, 1'b0, 8'h1C));
    cmp_got("t5_kerr");

    // online drop mid-send
    send_mp(32'hC1C2C3C4);
    wait_action("t6_action");
    busy = 1'b1;
    keyboard_valid = 1'b1;
    keyboard_data = 8'h2A;
    payload = 1'b1;
    tick();
    keyboard_valid = 1'b0;
    check("t6_b0", tx_data, 8'hC1);
    tick();
    check("t6_b1", tx_data, 8'hC2);
    payload = 1'b0;
    online = 1'b0;
    tick();
    check("t6_off_data", tx_data, 8'h00);
    check("t6_off_action", tx_action, 1'b0);
    online = 1'b1;
    busy = 1'b0;
    got.delete();
    n0 = n_act;
    payload = 1'b1;
    repeat (20) tick();
    payload = 1'b0;
    check("t6_flushed", n_act, n0);
    check("t6_no_events", got.size(), 0);
    check("t6_mdrop_kept", mouse_drop_count, 8'd1);

    // reset mid-send
    send_mp(32'hD1D2D3D4);
    wait_action("t7_action");
    payload = 1'b1;
    tick();
    check("t7_b0", tx_data, 8'hD1);
    payload = 1'b0;
    reset = 1'b0;
    tick();
    check_zero("t7_reset");
    reset = 1'b1;
    tick();
    got.delete();

    // randomized traffic against the event-level model
    e_f = 1'b0;
    b_f = 1'b0;
    payload = 1'b1;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 9))
          0, 1: begin send_k(8'hE0); e_f = 1'b1; end
          2, 3: begin send_k(8'hF0); b_f = 1'b1; end
          default: begin
            do code = 8'($urandom_range(0, 255));
            while (code == 8'hE0 || code == 8'hF0);
            send_k(code);
            exp_k.push_back(kev(e_f, b_f, code));
            e_f = 1'b0;
            b_f = 1'b0;
          end
        endcase
      end else begin
        pk = $urandom;
        send_mp(pk);
        exp_m.push_back(mev(pk));
      end
      repeat (10) tick();
    end
    repeat (40) tick();
    payload = 1'b0;
    foreach (got[i]) begin
      if (got[i][35]) got_m.push_back(got[i]);
      else            got_k.push_back(got[i]);
    end
    check("rnd_kcount", got_k.size(), exp_k.size());
    check("rnd_mcount", got_m.size(), exp_m.size());
    for (int i = 0; i < exp_k.size() && i < got_k.size(); i++)
      check("rnd_kev", got_k[i], exp_k[i]);
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
      check("rnd_mev", got_m[i], exp_m[i]);
    check("rnd_kdrop", kbd_drop_count, 8'd0);
    check("rnd_mdrop", mouse_drop_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_event_packer.md
Name: peripheral_event_packer

Overview:
Parametrised successor to the keyboard/mouse monitor in the client's data-tx path. It assembles PS/2 keyboard events (E0/F0 prefixes folded into one event) and N-byte mouse packets, then buffers each channel in its own event FIFO. A round-robin arbiter serialises events onto one shared tx interface paced by the transmitter's payload strobes. It adds error, timeout and overflow handling with saturating drop counters.

Parameters:
MOUSE_BYTES, 4, mouse packet length in bytes; legal values 3 or 4.
KBD_DEPTH, 4, keyboard FIFO depth in events; power of 2, at least 2.
MOUSE_DEPTH, 2, mouse FIFO depth in events; power of 2, at least 2.
MOUSE_TIMEOUT, 100000, idle cycles after which a partial mouse packet is discarded; at least 2.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
online  in  1  link up; 0 flushes the block (see Behaviour)
busy  in  1  transmitter busy; 1 blocks the start of a new event
payload  in  1  one-cycle strobe requesting the next byte of the current event
keyboard_valid  in  1  keyboard byte strobe
keyboard_error  in  1  keyboard frame error strobe
keyboard_data  in  8  keyboard byte
mouse_valid  in  1  mouse byte strobe
mouse_error  in  1  mouse frame error strobe
mouse_data  in  8  mouse byte
tx_action  out  1  one-cycle pulse marking the start of an event
tx_channel  out  1  0 = keyboard, 1 = mouse; valid from tx_action until the last byte
tx_length  out  3  byte count of the current event: 3 for keyboard, MOUSE_BYTES for mouse
tx_data  out  8  current event byte
kbd_drop_count  out  8  saturating count of dropped keyboard events
mouse_drop_count  out  8  saturating count of dropped or aborted mouse packets

Behaviour:
- Reset (reset=0 at an edge): all outputs 0; FIFOs empty; prefix flags, byte index and timeout counter cleared; arbiter favours keyboard first.
- Keyboard assembly:
  - 0xE0 sets the ext flag; 0xF0 sets the brk flag; nothing is pushed for either.
  - Any other code pushes {ext, brk, code} at the same edge, then both flags clear.
  - keyboard_error clears both flags, pushes nothing and increments kbd_drop_count.
  - error and valid in the same cycle: the error wins and the byte is ignored.
- Mouse assembly:
  - Bytes fill the packet MSB-first.
  - The MOUSE_BYTES-th byte pushes the packet and resets the byte index.
  - mouse_error with a partial or empty packet discards it, resets the index and increments mouse_drop_count.
  - Timeout: a counter runs while the index is nonzero and resets on each valid byte. When it reaches MOUSE_TIMEOUT the partial packet is discarded and mouse_drop_count increments.
- Overflow: a push into a full FIFO drops the new event and increments that channel's drop count. A pop and a push in the same cycle on a full FIFO both succeed.
- Drop counters saturate at 0xFF.
- Tx FSM, IDLE -> SEND:
  - IDLE: if online=1, busy=0 and either FIFO is non-empty at an edge, pop the granted FIFO and go to SEND. At that edge set tx_action=1 for one cycle and load tx_channel and tx_length.
  - When both FIFOs are non-empty, grant alternates, starting with the channel not served last.
  - IDLE holds tx_data=0x00.
- Latency: final byte sampled at edge N; FIFO non-empty in cycle N+1; tx_action high in cycle N+2 at the earliest.
- Byte order: keyboard event = (ext ? 0xE0 : 0x00), (brk ? 0xF0 : 0x00), code. Mouse event = bytes in arrival order.
- SEND:
  - Each payload=1 edge loads the next byte into tx_data and advances the index.
  - A payload during the tx_action cycle is honoured.
  - tx_data holds between strobes.
  - On the last byte, return to IDLE; the last byte is visible for exactly one cycle, then tx_data=0.
  - busy is ignored in SEND.
- online=0:
  - Aborts SEND without counting a drop; tx_data and tx_action go to 0.
  - Flushes both FIFOs and all partial assembly state.
  - Ignores all input strobes.
  - Drop counters are kept.
- Assembly continues during SEND; the FIFOs decouple it from transmission.

Test Plan:
1. Keyboard bytes E0, F0, 0x75 with busy=0, then three payload strobes -> one tx_action with tx_channel=0, tx_length=3; tx_data = E0, F0, 75, then 00.
2. Mouse bytes 08, 01, FF, 00 (MOUSE_BYTES=4) -> tx_action in cycle N+2 after the 4th byte; tx_channel=1; data 08, 01, FF, 00.
3. Both channels receive events while busy=1, then busy drops -> events sent keyboard, mouse, keyboard, mouse; no byte interleaving within an event.
4. busy=1 and 5 keyboard codes pushed (KBD_DEPTH=4) -> kbd_drop_count=1; first 4 events sent in order; 256 or more drops -> counter holds at 0xFF.
5. MOUSE_TIMEOUT=16: two mouse bytes then 16 idle cycles -> mouse_drop_count=1; next 4 bytes form a clean packet. Separately, keyboard E0 then keyboard_error, then 0x1C -> event 00, 00, 1C.
6. online dropped after the 2nd payload of a mouse event -> tx_data=0, no further bytes, FIFOs empty. Separately, reset=0 mid-SEND -> all outputs 0 the next cycle.
